// File: rtl/uart_rx_sniffer.sv
// UART line monitor: 16x oversampled receiver with 3-sample majority vote,
// parity/framing/break/overrun detection and a show-ahead receive FIFO.
module uart_rx_sniffer #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   input  logic                        rx,
   input  logic [DIV_W-1:0]            baud_div,
   input  logic [3:0]                  data_bits,
   input  logic [1:0]                  parity_mode,
   input  logic                        stop2,
   input  logic                        rd_en,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        rd_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        frame_err,
   output logic                        parity_err,
   output logic                        overrun_err,
   output logic                        break_det,
   input  logic                        err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [3:0] clamp_bits(input logic [3:0] b);
      if (b < 4'd5)
         return 4'd5;
      else if (b > 4'(DATA_W))
         return 4'(DATA_W);
      else
         return b;
   endfunction

   logic              rx_p0, rx_p1, rx_p2;
   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [3:0]        sub_cnt, bit_cnt, nbits;
   logic              s7, s8;
   logic [DATA_W-1:0] shreg;
   logic              par_bit, stops_one, stops_zero;
   logic              tick, vote, finish, par_en, par_bad;
   logic              stops_one_f, stops_zero_f, data_zero;

   logic              vld_p0;
   logic [DATA_W-1:0] data_p0;
   logic              frame_set_p0, parity_set_p0, break_set_p0;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     level;
   logic              pop, full, wr_ok;

   // stage p0..p2: input synchroniser plus one extra flop for edge detection
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   always_comb begin
      nbits        = clamp_bits(data_bits);
      tick         = (state != IDLE) && (div_cnt == baud_div);
      vote         = maj3(s7, s8, rx_p1);
      par_en       = (parity_mode == 2'd1) || (parity_mode == 2'd2);
      par_bad      = par_en && (par_bit != ((parity_mode == 2'd2) ? ~(^shreg) : (^shreg)));
      finish       = tick && (sub_cnt == 4'd9) &&
                     (((state == STOP1) && !stop2) || (state == STOP2));
      stops_one_f  = stops_one & vote;
      stops_zero_f = stops_zero & ~vote;
      data_zero    = (shreg == '0) && !(par_en && par_bit);
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state         <= IDLE;
         div_cnt       <= '0;
         sub_cnt       <= '0;
         bit_cnt       <= '0;
         s7            <= 1'b0;
         s8            <= 1'b0;
         shreg         <= '0;
         par_bit       <= 1'b0;
         stops_one     <= 1'b1;
         stops_zero    <= 1'b1;
         vld_p0        <= 1'b0;
         data_p0       <= '0;
         frame_set_p0  <= 1'b0;
         parity_set_p0 <= 1'b0;
         break_set_p0  <= 1'b0;
      end else begin
         vld_p0        <= 1'b0;
         frame_set_p0  <= 1'b0;
         parity_set_p0 <= 1'b0;
         break_set_p0  <= 1'b0;
         if (state == IDLE) begin
            div_cnt <= '0;
            sub_cnt <= '0;
            // After a break the line is still low, so no edge is seen until it idles high again.
            if (rx_p2 && !rx_p1) begin
               state      <= START;
               bit_cnt    <= '0;
               shreg      <= '0;
               par_bit    <= 1'b0;
               stops_one  <= 1'b1;
               stops_zero <= 1'b1;
            end
         end else if (!tick) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end else begin
            div_cnt <= '0;
            sub_cnt <= sub_cnt + 4'd1;
            if (sub_cnt == 4'd7) s7 <= rx_p1;
            if (sub_cnt == 4'd8) s8 <= rx_p1;
            if (finish) begin
               state <= IDLE;
               if (!stops_one_f) begin
                  if (data_zero && stops_zero_f)
                     break_set_p0 <= 1'b1;
                  else
                     frame_set_p0 <= 1'b1;
               end else begin
                  vld_p0        <= 1'b1;
                  data_p0       <= shreg;
                  parity_set_p0 <= par_bad;
               end
            end else begin
               case (state)
                  START: begin
                     if ((sub_cnt == 4'd9) && vote)
                        state <= IDLE;
                     else if (sub_cnt == 4'd15)
                        state <= DATA;
                  end
                  DATA: begin
                     if (sub_cnt == 4'd9)
                        shreg <= shreg | (DATA_W'(vote) << bit_cnt);
                     if (sub_cnt == 4'd15) begin
                        if (bit_cnt == nbits - 4'd1)
                           state <= par_en ? PARITY : STOP1;
                        else
                           bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
                  PARITY: begin
                     if (sub_cnt == 4'd9)  par_bit <= vote;
                     if (sub_cnt == 4'd15) state   <= STOP1;
                  end
                  STOP1: begin
                     // only reached here with two stop bits; the one-stop case finishes above
                     if (sub_cnt == 4'd9) begin
                        stops_one  <= vote;
                        stops_zero <= ~vote;
                     end
                     if (sub_cnt == 4'd15) state <= STOP2;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      pop   = rd_en && (level != '0);
      full  = (level == LW'(FIFO_DEPTH));
      wr_ok = vld_p0 && (!full || pop);
   end

   // stage p1: FIFO write and sticky flag update, one cycle after frame completion
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= data_p0;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (wr_ok && !pop)
            level <= level + LW'(1);
         else if (!wr_ok && pop)
            level <= level - LW'(1);
         frame_err   <= (frame_err   & ~err_clr) | frame_set_p0;
         parity_err  <= (parity_err  & ~err_clr) | parity_set_p0;
         break_det   <= (break_det   & ~err_clr) | break_set_p0;
         overrun_err <= (overrun_err & ~err_clr) | (vld_p0 && full && !pop);
      end
   end

   assign rd_data    = mem[rd_ptr];
   assign rd_valid   = (level != '0);
   assign fifo_level = level;

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Directed bench for uart_rx_sniffer: table of frame vectors plus hand-written
// sequences for glitches, sticky-flag clear races, overrun and mid-frame reset.
module tb_uart_rx_sniffer;

   localparam int DW = 9;

   logic          clk = 1'b0;
   logic          hreset, rx, stop2, rd_en, err_clr;
   logic [15:0]   baud_div;
   logic [3:0]    data_bits;
   logic [1:0]    parity_mode;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [2:0]    fifo_level;
   logic          frame_err, parity_err, overrun_err, break_det;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_rx_sniffer #(.DATA_W(DW), .FIFO_DEPTH(4), .DIV_W(16)) dut (
      .HCLK(clk), .HRESET(hreset), .rx(rx), .baud_div(baud_div),
      .data_bits(data_bits), .parity_mode(parity_mode), .stop2(stop2),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_level(fifo_level), .frame_err(frame_err), .parity_err(parity_err),
      .overrun_err(overrun_err), .break_det(break_det), .err_clr(err_clr)
   );

   typedef struct {
      int d; int cfg; int nb; int pm; int s2; int pflip; int stopv; int glitch;
      int push; int exp_d; int fe; int pe; int brk; int lat;
   } vec_t;

   vec_t vt[14];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_flags(input string name, input int fe, input int pe, input int ov, input int brk);
      check({name, " frame_err"},   int'(frame_err),   fe);
      check({name, " parity_err"},  int'(parity_err),  pe);
      check({name, " overrun_err"}, int'(overrun_err), ov);
      check({name, " break_det"},   int'(break_det),   brk);
   endtask

   task automatic set_cfg(input int nb, input int pm, input int s2);
      data_bits   = 4'(nb);
      parity_mode = 2'(pm);
      stop2       = s2[0];
   endtask

   task automatic pulse_clr();
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
   endtask

   task automatic pop_check(input string name, input int exp);
      check({name, " rd_data"}, int'(rd_data), exp);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   // Drives one frame at 16 clocks per bit. *_at give the in-frame cycle index at
   // which err_clr / rd_en / HRESET are pulsed for one cycle (-1 = never).
   task automatic send_frame(input int d, input int nb, input int pm, input int s2,
                             input int pflip, input int stopv, input int glitch,
                             input int clr_at, input int rd_at, input int rst_at,
                             output int lat);
      logic        fb [16];
      logic [31:0] dv;
      logic        pb;
      int          n;
      dv = d;
      pb = 1'b0;
      fb[0] = 1'b0;
      for (int i = 0; i < nb; i++) begin
         fb[1+i] = dv[i];
         pb ^= dv[i];
      end
      if (pm == 2) pb = ~pb;
      pb ^= pflip[0];
      n = 1 + nb;
      if (pm == 1 || pm == 2) begin
         fb[n] = pb;
         n++;
      end
      fb[n] = stopv[0];
      n++;
      if (s2 != 0) begin
         fb[n] = stopv[0];
         n++;
      end
      lat = -1;
      @(negedge clk);
      for (int j = 0; j < n; j++) begin
         for (int k = 0; k < 16; k++) begin
            rx      = (j == glitch && k == 9) ? ~fb[j] : fb[j];
            err_clr = ((16*j + k) == clr_at);
            rd_en   = ((16*j + k) == rd_at);
            hreset  = ((16*j + k) == rst_at);
            @(negedge clk);
            if (rd_valid && lat < 0) lat = 16*j + k + 1;
         end
      end
      rx = 1'b1; err_clr = 1'b0; rd_en = 1'b0; hreset = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      //         d     cfg nb pm s2 pf st gl  push exp_d  fe pe brk lat
      vt[0]  = '{'h055,  8, 8, 0, 0, 0, 1, -1, 1, 'h055, 0, 0, 0, 158};
      vt[1]  = '{'h041,  7, 7, 1, 1, 0, 1, -1, 1, 'h041, 0, 0, 0, 0};
      vt[2]  = '{'h041,  7, 7, 1, 1, 1, 1, -1, 1, 'h041, 0, 1, 0, 0};
      vt[3]  = '{'h1A5,  9, 9, 2, 0, 0, 1, -1, 1, 'h1A5, 0, 0, 0, 0};
      vt[4]  = '{'h0C3,  8, 8, 0, 0, 0, 1,  3, 1, 'h0C3, 0, 0, 0, 0};
      vt[5]  = '{'h03C,  8, 8, 0, 0, 0, 0, -1, 0, 'h000, 1, 0, 0, 0};
      vt[6]  = '{'h015,  5, 5, 0, 0, 0, 1, -1, 1, 'h015, 0, 0, 0, 0};
      vt[7]  = '{'h00B,  3, 5, 0, 0, 0, 1, -1, 1, 'h00B, 0, 0, 0, 0};
      vt[8]  = '{'h155, 15, 9, 0, 0, 0, 1, -1, 1, 'h155, 0, 0, 0, 0};
      vt[9]  = '{'h000,  8, 8, 2, 0, 0, 1, -1, 1, 'h000, 0, 0, 0, 0};
      vt[10] = '{'h02A,  6, 6, 3, 1, 0, 1, -1, 1, 'h02A, 0, 0, 0, 0};
      vt[11] = '{'h0B6,  8, 8, 1, 1, 0, 1, -1, 1, 'h0B6, 0, 0, 0, 0};
      vt[12] = '{'h000,  8, 8, 0, 0, 0, 0, -1, 0, 'h000, 0, 0, 1, 0};
      vt[13] = '{'h00D,  8, 8, 0, 0, 0, 1, -1, 1, 'h00D, 0, 0, 0, 0};

      hreset = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      baud_div = 16'd0; set_cfg(8, 0, 0);
      repeat (3) @(negedge clk);
      hreset = 1'b0;
      check("reset rd_valid", int'(rd_valid), 0);
      check("reset level", int'(fifo_level), 0);
      check("reset rd_data", int'(rd_data), 0);
      check_flags("reset", 0, 0, 0, 0);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         set_cfg(vt[i].cfg, vt[i].pm, vt[i].s2);
         pulse_clr();
         send_frame(vt[i].d, vt[i].nb, vt[i].pm, vt[i].s2, vt[i].pflip, vt[i].stopv,
                    vt[i].glitch, -1, -1, -1, lat);
         check($sformatf("row%0d level", i), int'(fifo_level), vt[i].push);
         check_flags($sformatf("row%0d", i), vt[i].fe, vt[i].pe, 0, vt[i].brk);
         if (vt[i].lat != 0) check($sformatf("row%0d latency", i), lat, vt[i].lat);
         if (vt[i].push != 0) begin
            pop_check($sformatf("row%0d", i), vt[i].exp_d);
            check($sformatf("row%0d drained", i), int'(rd_valid), 0);
         end
      end

      // Short low pulse on an idle line is a false start.
      set_cfg(8, 0, 0);
      pulse_clr();
      @(negedge clk) rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch level", int'(fifo_level), 0);
      check_flags("glitch", 0, 0, 0, 0);

      // New frame error lands on the same cycle as err_clr: set must win.
      check("clr race pre frame_err", int'(frame_err), 0);
      send_frame('h3C, 8, 0, 0, 0, 0, -1, 157, -1, -1, lat);
      check("clr race frame_err", int'(frame_err), 1);
      check("clr race level", int'(fifo_level), 0);
      pulse_clr();
      check("clr frame_err", int'(frame_err), 0);

      // Overrun: five characters into a four-entry FIFO.
      for (int v = 1; v <= 5; v++) send_frame(v, 8, 0, 0, 0, 1, -1, -1, -1, -1, lat);
      check("ovr level", int'(fifo_level), 4);
      check("ovr flag", int'(overrun_err), 1);
      for (int v = 1; v <= 4; v++) pop_check($sformatf("ovr pop%0d", v), v);
      check("ovr drained", int'(rd_valid), 0);
      rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
      check("empty pop level", int'(fifo_level), 0);
      check("empty pop valid", int'(rd_valid), 0);

      // Same again with a pop on the fifth push cycle.
      pulse_clr();
      for (int v = 1; v <= 4; v++) send_frame(v, 8, 0, 0, 0, 1, -1, -1, -1, -1, lat);
      send_frame(5, 8, 0, 0, 0, 1, -1, -1, 157, -1, lat);
      check("full pop level", int'(fifo_level), 4);
      check("full pop overrun", int'(overrun_err), 0);
      for (int v = 2; v <= 5; v++) pop_check($sformatf("full pop%0d", v), v);

      // Reset during data bit 3 wipes FIFO and flags; the remainder of the frame decodes as a false start.
      send_frame('h11, 8, 0, 0, 0, 1, -1, -1, -1, -1, lat);
      send_frame('h3C, 8, 0, 0, 0, 0, -1, -1, -1, -1, lat);
      check("pre rst level", int'(fifo_level), 1);
      check("pre rst frame_err", int'(frame_err), 1);
      send_frame('hF0, 8, 0, 0, 0, 1, -1, -1, -1, 72, lat);
      check("rst level", int'(fifo_level), 0);
      check("rst rd_valid", int'(rd_valid), 0);
      check("rst rd_data", int'(rd_data), 0);
      check_flags("rst", 0, 0, 0, 0);
      send_frame('hA7, 8, 0, 0, 0, 1, -1, -1, -1, -1, lat);
      check("post rst level", int'(fifo_level), 1);
      check_flags("post rst", 0, 0, 0, 0);
      pop_check("post rst", 'hA7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
